// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: self-contained AXI-Stream frame source for Tx link bring-up.
// Each frame is PREAMBLE_LEN preamble bytes, one header byte {mode, frame_cnt[3:0]},
// then PAYLOAD_LEN bytes from a free-running LFSR, followed by a fixed idle gap.
// Optional build macro TX_FRAME_CRC_EN appends a CRC-8 byte (poly 0x07, init 0x00,
// MSB-first) over header+payload and moves tlast onto it.
// All stream outputs are registered; tready never reaches tvalid combinationally.

module tx_frame_scheduler #(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
    parameter int unsigned PAYLOAD_LEN   = 16,
    parameter int unsigned GAP_CYCLES    = 32
) (
    input  logic        clk_1M024,
    input  logic        rst_n_1M024,
    input  logic        en,
    input  logic [3:0]  MODE_CTRL,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    input  logic        data_tready,
    output logic        data_tlast,
    output logic        data_tuser,
    output logic [3:0]  mode_latched,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
`ifdef TX_FRAME_CRC_EN
        ST_CRC,
`endif
        ST_GAP
    } state_t;

    // Terminal values of the shared byte/cycle counter in each state.
    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] PAY_LAST = 8'(PAYLOAD_LEN - 1);
    // A zero-length gap still occupies one cycle, so both 0 and 1 end after one cycle.
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    // Fibonacci LFSR, shift left, new bit0 = b7^b5^b4^b3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

`ifdef TX_FRAME_CRC_EN
    // CRC-8, poly 0x07, one byte folded in MSB-first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    logic [7:0] r_crc;
`endif

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;
    logic [3:0]  r_mode;
    logic [15:0] r_frame_cnt;
    logic        r_busy;

    logic        w_xfer;
    logic        w_mode_legal;
    logic        w_start;
    logic [7:0]  w_header;
    logic [7:0]  w_lfsr_next;

    assign w_xfer       = r_tvalid && data_tready;
    assign w_mode_legal = (MODE_CTRL == 4'b0001) || (MODE_CTRL == 4'b0010) ||
                          (MODE_CTRL == 4'b0100);
    // Mode latch points: IDLE, or the final cycle of the inter-frame gap.
    assign w_start      = en && w_mode_legal &&
                          ((r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_cnt == GAP_LAST)));
    assign w_header     = {r_mode, r_frame_cnt[3:0]};
    assign w_lfsr_next  = lfsr_step(r_lfsr);

    // Frame sequencer: state, counters and every stream output in one registered block.
    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking ones would make results depend on statement order.
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_lfsr      <= 8'hFF;
            r_tdata     <= 8'd0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_mode      <= 4'b0001;
            r_frame_cnt <= 16'd0;
            r_busy      <= 1'b0;
`ifdef TX_FRAME_CRC_EN
            r_crc       <= 8'd0;
`endif
        end else if (w_start) begin
            // Present the first preamble byte on the very next cycle.
            r_state  <= ST_PREAMBLE;
            r_mode   <= MODE_CTRL;
            r_cnt    <= 8'd0;
            r_tdata  <= PREAMBLE_BYTE;
            r_tvalid <= 1'b1;
            r_tuser  <= 1'b1;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b1;
`ifdef TX_FRAME_CRC_EN
            r_crc    <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                end

                ST_PREAMBLE: begin
                    if (w_xfer) begin
                        r_tuser <= 1'b0;
                        if (r_cnt == PRE_LAST) begin
                            r_state <= ST_HEADER;
                            r_cnt   <= 8'd0;
                            r_tdata <= w_header;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end

                ST_HEADER: begin
                    if (w_xfer) begin
                        r_state <= ST_PAYLOAD;
                        r_cnt   <= 8'd0;
                        r_tdata <= r_lfsr;
`ifdef TX_FRAME_CRC_EN
                        r_crc   <= crc8_byte(r_crc, r_tdata);
`else
                        r_tlast <= (PAY_LAST == 8'd0);
`endif
                    end
                end

                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        // The LFSR keeps running across frames; it is only seeded by reset.
                        r_lfsr <= w_lfsr_next;
`ifdef TX_FRAME_CRC_EN
                        r_crc  <= crc8_byte(r_crc, r_tdata);
`endif
                        if (r_cnt == PAY_LAST) begin
                            r_cnt <= 8'd0;
`ifdef TX_FRAME_CRC_EN
                            r_state <= ST_CRC;
                            r_tdata <= crc8_byte(r_crc, r_tdata);
                            r_tlast <= 1'b1;
`else
                            r_state     <= ST_GAP;
                            r_tdata     <= 8'd0;
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_tdata <= w_lfsr_next;
`ifndef TX_FRAME_CRC_EN
                            r_tlast <= ((r_cnt + 8'd1) == PAY_LAST);
`endif
                        end
                    end
                end

`ifdef TX_FRAME_CRC_EN
                ST_CRC: begin
                    if (w_xfer) begin
                        r_state     <= ST_GAP;
                        r_cnt       <= 8'd0;
                        r_tdata     <= 8'd0;
                        r_tvalid    <= 1'b0;
                        r_tlast     <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
`endif

                ST_GAP: begin
                    // Reaching here on the last gap cycle means no restart: fall back to IDLE.
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign data_tdata   = r_tdata;
    assign data_tvalid  = r_tvalid;
    assign data_tlast   = r_tlast;
    assign data_tuser   = r_tuser;
    assign mode_latched = r_mode;
    assign frame_cnt    = r_frame_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: self-checking bench for tx_frame_scheduler.
// A reference model pushes the expected byte stream into a queue; a monitor pops and
// compares one entry per transfer. Mode legality is covered by a vector table.
`timescale 1ns/1ps

module tb_tx_frame_scheduler;

    localparam int PRE = 4;
    localparam int PAY = 16;
    localparam int GAP = 32;
`ifdef TX_FRAME_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif
    localparam int FRAME_BYTES = PRE + 1 + PAY + CRC_EXTRA;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        logic       en;
        logic [3:0] mode;
        logic       exp_busy;
        logic [3:0] exp_mode;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  mode_ctrl = 4'b0001;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic        tuser;
    logic [3:0]  mode_latched;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    beat_t exp_q[$];
    beat_t log_q[$];
    beat_t ref_log[$];
    logic [7:0]  m_lfsr = 8'hFF;
    logic [15:0] m_fc = 16'd0;

    logic  sb_en = 1'b0;
    logic  stall_en = 1'b0;
    logic  tready_cfg = 1'b1;
    logic  prev_stall = 1'b0;
    beat_t held;
    logic  gap_cnting = 1'b0;
    logic  have_gap = 1'b0;
    int    gap_cnt = 0;
    int    last_gap = -1;

    vec_t vecs[9];

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .PREAMBLE_LEN (PRE),
        .PREAMBLE_BYTE(8'hAA),
        .PAYLOAD_LEN  (PAY),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk_1M024   (clk),
        .rst_n_1M024 (rst_n),
        .en          (en),
        .MODE_CTRL   (mode_ctrl),
        .data_tdata  (tdata),
        .data_tvalid (tvalid),
        .data_tready (tready),
        .data_tlast  (tlast),
        .data_tuser  (tuser),
        .mode_latched(mode_latched),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR: feedback taps b7,b5,b4,b3 as a parity mask.
    function automatic logic [7:0] ref_lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

`ifdef TX_FRAME_CRC_EN
    // Reference CRC-8 (poly 0x07), processed one data bit at a time, MSB first.
    function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    task automatic push_frame(input logic [3:0] mode);
        logic [7:0] hdr;
`ifdef TX_FRAME_CRC_EN
        logic [7:0] crc;
        crc = 8'h00;
`endif
        for (int i = 0; i < PRE; i++) exp_q.push_back({8'hAA, 1'b0, (i == 0)});
        hdr = {mode, m_fc[3:0]};
        exp_q.push_back({hdr, 1'b0, 1'b0});
`ifdef TX_FRAME_CRC_EN
        crc = ref_crc8(crc, hdr);
`endif
        for (int i = 0; i < PAY; i++) begin
            exp_q.push_back({m_lfsr, ((i == PAY - 1) && (CRC_EXTRA == 0)), 1'b0});
`ifdef TX_FRAME_CRC_EN
            crc = ref_crc8(crc, m_lfsr);
`endif
            m_lfsr = ref_lfsr_next(m_lfsr);
        end
`ifdef TX_FRAME_CRC_EN
        exp_q.push_back({crc, 1'b1, 1'b0});
`endif
        m_fc = m_fc + 16'd1;
    endtask

    // tready source: fixed value or 50% random stalls, changed just after each edge.
    always @(posedge clk) begin
        #1;
        tready = stall_en ? 1'($urandom_range(0, 1)) : tready_cfg;
    end

    // Monitor: sampled on the falling edge, ahead of the rising edge that transfers.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (sb_en && rst_n) begin
            cur = {tdata, tlast, tuser};
            if (prev_stall) begin
                check("tvalid_held_in_stall", 32'(tvalid), 32'd1);
                check("beat_held_in_stall", 32'(cur), 32'(held));
            end
            if (tvalid) begin
                if (gap_cnting) begin
                    last_gap   = gap_cnt;
                    gap_cnting = 1'b0;
                    have_gap   = 1'b1;
                end
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_byte: got %0h expected no transfer at %0t", cur, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d", log_q.size()), 32'(cur), 32'(e));
                    end
                    log_q.push_back(cur);
                    if (tlast) begin
                        gap_cnting = 1'b1;
                        gap_cnt    = 0;
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held       = cur;
                end
            end else begin
                if (gap_cnting) gap_cnt++;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic do_reset();
        sb_en = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        log_q.delete();
        m_lfsr     = 8'hFF;
        m_fc       = 16'd0;
        prev_stall = 1'b0;
        gap_cnting = 1'b0;
        have_gap   = 1'b0;
        last_gap   = -1;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset(input logic sb);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = sb;
    endtask

    task automatic wait_remaining(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 32'(exp_q.size() <= n), 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached, got no end expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int k;

        vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0001};
        vecs[1] = '{1'b1, 4'b0011, 1'b0, 4'b0001};
        vecs[2] = '{1'b1, 4'b1000, 1'b0, 4'b0001};
        vecs[3] = '{1'b1, 4'b0111, 1'b0, 4'b0001};
        vecs[4] = '{1'b0, 4'b0010, 1'b0, 4'b0001};
        vecs[5] = '{1'b1, 4'b0001, 1'b1, 4'b0001};
        vecs[6] = '{1'b1, 4'b0010, 1'b1, 4'b0010};
        vecs[7] = '{1'b1, 4'b0100, 1'b1, 4'b0100};
        vecs[8] = '{1'b1, 4'b1111, 1'b0, 4'b0001};

        // Mode legality / enable table.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            en         = vecs[i].en;
            mode_ctrl  = vecs[i].mode;
            tready_cfg = 1'b1;
            release_reset(1'b0);
            wait_cycles(3);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_mode_latched", i), 32'(mode_latched), 32'(vecs[i].exp_mode));
        end

        // Basic two-frame run, no stalls; en dropped in the 2nd frame's payload.
        do_reset();
        en = 1'b1; mode_ctrl = 4'b0001; tready_cfg = 1'b1;
        wait_cycles(1);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tuser", 32'(tuser), 32'd0);
        check("rst_mode_latched", 32'(mode_latched), 32'h1);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        push_frame(4'b0001);
        push_frame(4'b0001);
        release_reset(1'b1);
        @(negedge clk);
        check("tvalid_before_first_edge", 32'(tvalid), 32'd0);
        @(negedge clk);
        check("tvalid_one_cycle_after_release", 32'(tvalid), 32'd1);
        check("first_tuser", 32'(tuser), 32'd1);
        wait_remaining(FRAME_BYTES, 200, "frame1_done");
        wait_cycles(2);
        check("frame_cnt_after_1", 32'(frame_cnt), 32'd1);
        k = 0;
        while (!have_gap && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("gap_cycles", 32'(last_gap), 32'(GAP));
        wait_remaining(PAY - 4 + CRC_EXTRA, 200, "reach_payload5");
        en = 1'b0;
        wait_remaining(0, 200, "frame2_drain");
        wait_cycles(GAP + 4);
        check("idle_busy_after_en_drop", 32'(busy), 32'd0);
        check("idle_tvalid_after_en_drop", 32'(tvalid), 32'd0);
        check("frame_cnt_after_2", 32'(frame_cnt), 32'd2);
        check("log_size_2frames", 32'(log_q.size()), 32'(2 * FRAME_BYTES));
        if (log_q.size() >= 2 * FRAME_BYTES) begin
            check("b0_preamble_tuser", 32'(log_q[0]), 32'({8'hAA, 1'b0, 1'b1}));
            check("b1_no_tuser", 32'(log_q[1].user), 32'd0);
            check("hdr1", 32'(log_q[PRE].data), 32'h10);
            check("pay0", 32'(log_q[PRE + 1].data), 32'hFF);
            check("pay1", 32'(log_q[PRE + 2].data), 32'hFE);
            check("pay2", 32'(log_q[PRE + 3].data), 32'hFC);
            check("tlast_on_last", 32'(log_q[FRAME_BYTES - 1].last), 32'd1);
            check("no_tlast_before_last", 32'(log_q[FRAME_BYTES - 2].last), 32'd0);
            check("hdr2", 32'(log_q[FRAME_BYTES + PRE].data), 32'h11);
        end
        ref_log = log_q;

        // Random 50% stalls over three frames.
        do_reset();
        en = 1'b1; mode_ctrl = 4'b0001;
        push_frame(4'b0001);
        push_frame(4'b0001);
        push_frame(4'b0001);
        stall_en = 1'b1;
        release_reset(1'b1);
        wait_remaining(FRAME_BYTES - 6, 3000, "stall_reach_frame3");
        en = 1'b0;
        wait_remaining(0, 1000, "stall_drain");
        stall_en = 1'b0;
        wait_cycles(GAP + 4);
        check("stall_busy_idle", 32'(busy), 32'd0);
        check("stall_frame_cnt", 32'(frame_cnt), 32'd3);
        mism = 0;
        for (int i = 0; i < 2 * FRAME_BYTES; i++) begin
            if (i >= log_q.size() || i >= ref_log.size() || log_q[i] != ref_log[i]) mism++;
        end
        check("stall_vs_nostall_bytes", 32'(mism), 32'd0);

        // Illegal multi-hot mode holds IDLE; then a legal QPSK frame, with a mid-frame mode change.
        do_reset();
        en = 1'b1; mode_ctrl = 4'b0011; tready_cfg = 1'b1;
        release_reset(1'b1);
        wait_cycles(5);
        check("illegal_busy", 32'(busy), 32'd0);
        check("illegal_tvalid", 32'(tvalid), 32'd0);
        push_frame(4'b0010);
        mode_ctrl = 4'b0010;
        wait_cycles(2);
        check("qpsk_mode_latched", 32'(mode_latched), 32'h2);
        check("qpsk_busy", 32'(busy), 32'd1);
        mode_ctrl = 4'b0100;
        en = 1'b0;
        wait_remaining(0, 200, "qpsk_drain");
        check("qpsk_mode_held", 32'(mode_latched), 32'h2);
        if (log_q.size() > PRE) check("qpsk_hdr_nibble", 32'(log_q[PRE].data[7:4]), 32'h2);
        wait_cycles(GAP + 4);
        check("qpsk_idle", 32'(busy), 32'd0);

        // Reset asserted while the header byte is on the bus.
        do_reset();
        en = 1'b1; mode_ctrl = 4'b0001; tready_cfg = 1'b1;
        push_frame(4'b0001);
        release_reset(1'b1);
        k = 0;
        while (log_q.size() < PRE && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        check("in_header_before_reset", 32'(tdata), 32'h10);
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_tdata", 32'(tdata), 32'd0);
        check("async_rst_tvalid", 32'(tvalid), 32'd0);
        check("async_rst_tlast", 32'(tlast), 32'd0);
        check("async_rst_tuser", 32'(tuser), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("async_rst_mode", 32'(mode_latched), 32'h1);
        do_reset();
        push_frame(4'b0001);
        release_reset(1'b1);
        wait_cycles(3);
        en = 1'b0;
        wait_remaining(0, 200, "post_reset_drain");
        if (log_q.size() > PRE + 1) check("post_reset_pay0", 32'(log_q[PRE + 1].data), 32'hFF);
        wait_cycles(GAP + 4);
        check("post_reset_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
